bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//  Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop
//  processes WIDTH-bit operands LSB-first, one bit per clock, with start/busy/done handshake.
//  Sequential successor to the combinational full-adder cell in the gate library.
//  Trades latency for area in the lab datapath.
// PARAMETERS
//  WIDTH      8   operand/result width in bits; legal range 2..32
//  SUB_EN     1   1: sub input honoured; 0: sub tied off internally, add only
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only when busy==0
//  sub        in   1      0: a+b, 1: a-b (two's complement); sampled with start
//  a          in   WIDTH  operand A; sampled with start
//  b          in   WIDTH  operand B; sampled with start
//  busy       out  1      high while bits are being processed
//  done       out  1      one-cycle pulse: result valid
//  sum        out  WIDTH  result; held until next completion
//  carry_out  out  1      final carry (sub: 1 = no borrow, i.e. a>=b unsigned)
//  overflow   out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0;
//   shift registers, bit counter and carry FF cleared. An operation in flight is abandoned;
//   no done pulse follows.
//  FSM states: IDLE, RUN, DONE.
//   IDLE/DONE + start=1: latch a->A_sr, (sub ? ~b : b)->B_sr, carry FF = sub&SUB_EN,
//    cnt=0; go to RUN.
//   IDLE/DONE + start=0: DONE->IDLE; IDLE stays.
//   RUN: each cycle, bit s = A_sr[0]^B_sr[0]^c and new c = maj(A_sr[0],B_sr[0],c).
//    Shift A_sr/B_sr right; shift s into MSB of work register; cnt++.
//    On cnt==WIDTH-1: record carry into MSB (the c before the last bit); go to DONE.
//   DONE entry: sum=work reg; carry_out=final c; overflow=c_in_msb^c_out. done=1 for
//    exactly one cycle.
//  busy=1 only in RUN. start while busy is ignored; operands are not re-sampled.
//  Latency: start sampled at edge k -> done=1 in the cycle after edge k+WIDTH.
//   Back-to-back: start may be asserted during the done cycle; no idle gap is needed.
//  sum/carry_out/overflow change only on DONE entry or reset. During a subsequent RUN they
//   keep the previous result.
//  Width rules: internal work reg WIDTH bits; cnt width $clog2(WIDTH); carry is 1 bit.
//   No result wider than WIDTH; wrap-around is modulo 2^WIDTH.
//  SUB_EN=0: sub ignored; behaves as sub=0.
// STRUCTURE
//  Shared header (adder_defs.vh): FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//   and the WIDTH legality check macro.
//  One sub-module: the existing full_adder gate cell for the per-bit sum/carry, instantiated
//   once. Shift registers, counter, carry FF and FSM are in this module.
// TESTING (WIDTH=8 unless stated)
//  1 add a=0x35,b=0x4A -> sum=0x7F, carry_out=0, overflow=0; done exactly 9 cycles after
//    the start edge; busy high for 8 cycles.
//  2 add a=0xFF,b=0x01 -> sum=0x00, carry_out=1, overflow=0;
//    add a=0x7F,b=0x01 -> sum=0x80, carry_out=0, overflow=1.
//  3 sub a=0x10,b=0x20 -> sum=0xF0, carry_out=0, overflow=0;
//    sub a=0x80,b=0x01 -> sum=0x7F, carry_out=1, overflow=1.
//  4 start=1 with a=0x01,b=0x01 mid-RUN of op 0x35+0x4A -> ignored; result 0x7F, single
//    done. Start in done cycle -> next result after 9 more cycles.
//  5 rst_n=0 at cycle 4 of RUN -> all outputs 0 immediately (async); no done; fresh start
//    works.
//  6 WIDTH=16, SUB_EN=0: sub=1, a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1,
//    overflow=1, done at 17 cycles.

Source files
------------

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings, legal WIDTH range and the bit-cell helper.
package bit_serial_adder_pkg;

  // Controller states; encodings are fixed so they line up with the
  // existing gate-library documentation.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Elaboration-time legality check for the operand width.
  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  // Majority of three: the carry function of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Bit-cell result bundle.
  typedef struct packed {
    logic s;
    logic co;
  } fa_out_t;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single full-adder gate cell, reused once per clock by the serial adder.
module bit_serial_adder_fa
  import bit_serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_out_t res;

  // Pure combinational sum/carry of one bit position.
  always_comb begin
    res    = '0;
    res.s  = a ^ b ^ ci;
    res.co = maj3(a, b, ci);
  end

  assign s  = res.s;
  assign co = res.co;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop walks
// WIDTH-bit operands LSB-first, one bit per clock, with a start/busy/done
// handshake. Subtraction is a + ~b + 1 with the +1 preloaded into the carry.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("bit_serial_adder: WIDTH must be in 2..32");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             c;

  logic             sub_eff;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] work_nxt;

  // With SUB_EN=0 the sub request is masked so the block is add-only.
  assign sub_eff  = sub & SUB_EN;
  // Work register after shifting in the current sum bit at the MSB; on the
  // last bit this is the complete result.
  assign work_nxt = {bit_s, work[WIDTH-1:1]};

  bit_serial_adder_fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (c),
    .s  (bit_s),
    .co (bit_c)
  );

  // Controller, datapath shift registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      work      <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub_eff ? ~b : b;
            c     <= sub_eff;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          work <= work_nxt;
          c    <= bit_c;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // c still holds the carry into the MSB here, bit_c the carry out.
            sum       <= work_nxt;
            carry_out <= bit_c;
            overflow  <= c ^ bit_c;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: an 8-bit add/sub instance and a 16-bit
// add-only instance, both checked every cycle against an arithmetic model.
module tb_bit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i [2];
  logic        sub_i   [2];
  logic [31:0] a_i     [2];
  logic [31:0] b_i     [2];

  logic        busy8, done8, co8, ov8;
  logic [7:0]  sum8;
  logic        busy16, done16, co16, ov16;
  logic [15:0] sum16;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8), .SUB_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .sub(sub_i[0]),
    .a(a_i[0][7:0]), .b(b_i[0][7:0]), .busy(busy8), .done(done8),
    .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  bit_serial_adder #(.WIDTH(16), .SUB_EN(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .sub(sub_i[1]),
    .a(a_i[1][15:0]), .b(b_i[1][15:0]), .busy(busy16), .done(done16),
    .sum(sum16), .carry_out(co16), .overflow(ov16)
  );

  typedef struct {
    logic        busy;
    logic        done;
    logic        co;
    logic        ov;
    logic [31:0] sum;
  } obs_t;

  function automatic obs_t obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.busy = busy8;  o.done = done8;  o.co = co8;  o.ov = ov8;  o.sum = {24'd0, sum8};
    end else begin
      o.busy = busy16; o.done = done16; o.co = co16; o.ov = ov16; o.sum = {16'd0, sum16};
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: modulo-2^w add of a and (b or its two's
  // complement); overflow from the operand/result sign rules.
  task automatic ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, output logic [31:0] s, output logic co,
                        output logic ov);
    longint unsigned mask, bb, t;
    logic sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? ((~{32'd0, b}) & mask) : ({32'd0, b} & mask);
    t    = ({32'd0, a} & mask) + bb + {63'd0, sub};
    s    = 32'(t & mask);
    co   = t[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = s[w-1];
    ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
  endtask

  // Behavioural model: an accepted request produces its result exactly
  // WIDTH clocks later; requests while an operation is pending are dropped.
  int          mw   [2] = '{8, 16};
  bit          msub [2] = '{1'b1, 1'b0};
  logic        m_busy [2], m_done [2], m_co [2], m_ov [2];
  logic [31:0] m_sum  [2];
  logic        p_co   [2], p_ov [2];
  logic [31:0] p_sum  [2];
  int          m_left [2];

  always @(posedge clk or negedge rst_n) begin : model
    logic d;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0; m_done[k] = 1'b0; m_co[k] = 1'b0; m_ov[k] = 1'b0;
        m_sum[k]  = '0;   m_left[k] = 0;
      end else begin
        d = 1'b0;
        if (m_busy[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 1'b0;
            d         = 1'b1;
            m_sum[k]  = p_sum[k];
            m_co[k]   = p_co[k];
            m_ov[k]   = p_ov[k];
          end
        end else if (start_i[k]) begin
          ref_op(mw[k], a_i[k], b_i[k], sub_i[k] & msub[k], p_sum[k], p_co[k], p_ov[k]);
          m_busy[k] = 1'b1;
          m_left[k] = mw[k];
        end
        m_done[k] = d;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      o = obs(k);
      chk($sformatf("cyc%0d.busy", k), o.busy, m_busy[k]);
      chk($sformatf("cyc%0d.done", k), o.done, m_done[k]);
      chk($sformatf("cyc%0d.sum",  k), o.sum,  m_sum[k]);
      chk($sformatf("cyc%0d.cout", k), o.co,   m_co[k]);
      chk($sformatf("cyc%0d.ovf",  k), o.ov,   m_ov[k]);
    end
  end

  // Issue one request (caller sits just after a rising edge or at a falling
  // edge) and wait for done. lat = edges from the start edge to done.
  // Optionally pulse a second start with operands ja/jb junk_at edges in.
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input int junk_at, input logic [31:0] ja,
                       input logic [31:0] jb, output int lat, output int bcnt);
    a_i[k] = a; b_i[k] = b; sub_i[k] = sub; start_i[k] = 1'b1;
    @(posedge clk); #1;
    start_i[k] = 1'b0;
    lat = 0; bcnt = 0;
    while (1) begin
      if (obs(k).done) break;
      if (obs(k).busy) bcnt++;
      if (lat >= 200) begin
        n_chk++; n_err++;
        $display("FAIL timeout%0d: no done after %0d cycles, required within %0d", k, lat, mw[k]);
        break;
      end
      start_i[k] = (junk_at > 0) && (lat == junk_at);
      if (start_i[k]) begin a_i[k] = ja; b_i[k] = jb; sub_i[k] = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    start_i[k] = 1'b0;
  endtask

  task automatic count_done(input int k, input int ncyc, output int dcnt);
    dcnt = 0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (obs(k).done) dcnt++;
    end
  endtask

  task automatic rand_run(input int k, input int nops);
    int lat, bc, jk, g;
    for (int i = 0; i < nops; i++) begin
      jk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, mw[k] - 2)) : 0;
      do_op(k, $urandom, $urandom, 1'($urandom), jk, $urandom, $urandom, lat, bc);
      chk($sformatf("rnd%0d.lat", k), lat, mw[k]);
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, bc, dc;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; sub_i[k] = 1'b0; a_i[k] = '0; b_i[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst.busy", busy8, 1'b0);
    chk("rst.done", done8, 1'b0);
    chk("rst.sum",  sum8,  8'h00);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Plain add, latency and busy length.
    do_op(0, 32'h35, 32'h4A, 1'b0, 0, 0, 0, lat, bc);
    chk("t1.lat", lat, 8); chk("t1.busy", bc, 8);
    chk("t1.sum", sum8, 8'h7F); chk("t1.co", co8, 1'b0); chk("t1.ov", ov8, 1'b0);

    // Wrap with carry, then signed overflow; issued back-to-back.
    do_op(0, 32'hFF, 32'h01, 1'b0, 0, 0, 0, lat, bc);
    chk("t2a.lat", lat, 8);
    chk("t2a.sum", sum8, 8'h00); chk("t2a.co", co8, 1'b1); chk("t2a.ov", ov8, 1'b0);
    do_op(0, 32'h7F, 32'h01, 1'b0, 0, 0, 0, lat, bc);
    chk("t2b.sum", sum8, 8'h80); chk("t2b.co", co8, 1'b0); chk("t2b.ov", ov8, 1'b1);

    // Subtraction: borrow, then signed overflow.
    do_op(0, 32'h10, 32'h20, 1'b1, 0, 0, 0, lat, bc);
    chk("t3a.sum", sum8, 8'hF0); chk("t3a.co", co8, 1'b0); chk("t3a.ov", ov8, 1'b0);
    do_op(0, 32'h80, 32'h01, 1'b1, 0, 0, 0, lat, bc);
    chk("t3b.sum", sum8, 8'h7F); chk("t3b.co", co8, 1'b1); chk("t3b.ov", ov8, 1'b1);

    // Start while busy is ignored; then a start in the done cycle.
    do_op(0, 32'h35, 32'h4A, 1'b0, 3, 32'h01, 32'h01, lat, bc);
    chk("t4.lat", lat, 8); chk("t4.sum", sum8, 8'h7F);
    do_op(0, 32'h12, 32'h34, 1'b0, 0, 0, 0, lat, bc);
    chk("t4b2b.lat", lat, 8); chk("t4b2b.sum", sum8, 8'h46);
    count_done(0, 12, dc);
    chk("t4.extra_done", dc, 0);

    // Async reset mid-operation clears outputs at once; no done follows.
    a_i[0] = 32'h11; b_i[0] = 32'h22; sub_i[0] = 1'b0; start_i[0] = 1'b1;
    @(posedge clk); #1 start_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.busy", busy8, 1'b0); chk("t5.done", done8, 1'b0);
    chk("t5.sum", sum8, 8'h00);  chk("t5.co", co8, 1'b0); chk("t5.ov", ov8, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    count_done(0, 12, dc);
    chk("t5.no_done", dc, 0);
    do_op(0, 32'hC3, 32'h0F, 1'b0, 0, 0, 0, lat, bc);
    chk("t5.fresh_lat", lat, 8); chk("t5.fresh_sum", sum8, 8'hD2);

    // 16-bit add-only instance: sub is ignored.
    do_op(1, 32'h8000, 32'h8000, 1'b1, 0, 0, 0, lat, bc);
    chk("t6.lat", lat, 16); chk("t6.busy", bc, 16);
    chk("t6.sum", sum16, 16'h0000); chk("t6.co", co16, 1'b1); chk("t6.ov", ov16, 1'b1);

    // Randomized traffic on both instances concurrently.
    fork
      rand_run(0, 30);
      rand_run(1, 15);
    join

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
